regfile_dbg: RTL and testbench

REGFILE_DBG -- requirements
Module: regfile_dbg

---
 rtl/regfile_dbg.sv | 121 ++++++++++++
 tb/tb_regfile_dbg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg.sv
// rtl/regfile_dbg.sv - Two-read/one-write register file with a handshaked register dump port.
// Optional write-through read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_dbg #(
   parameter int DATA_W  = 16,
   parameter int NREG    = 8,
   parameter int ZERO_R0 = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [$clog2(NREG)-1:0]    waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [$clog2(NREG)-1:0]    raddr_a,
   input  logic [$clog2(NREG)-1:0]    raddr_b,
   output logic [DATA_W-1:0]          rdata_a,
   output logic [DATA_W-1:0]          rdata_b,
   input  logic                       dump_req,
   input  logic                       dump_ready,
   output logic                       dump_valid,
   output logic [$clog2(NREG)-1:0]    dump_idx,
   output logic [DATA_W-1:0]          dump_data,
   output logic                       dump_busy,
   output logic                       dump_done
);

   localparam int AW = $clog2(NREG);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] regs [NREG];
   logic [AW-1:0]     idx_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [AW-1:0]     cap_addr;
   logic [DATA_W-1:0] cap_val;
   logic              wr_ok;

   assign wr_ok = we && !((ZERO_R0 != 0) && (waddr == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = regs[raddr_a];
      if ((ZERO_R0 != 0) && (raddr_a == '0)) rdata_a = '0;
`ifdef REGFILE_BYPASS_EN
      else if (wr_ok && (waddr == raddr_a)) rdata_a = wdata;
`endif
   end

   always_comb begin
      rdata_b = regs[raddr_b];
      if ((ZERO_R0 != 0) && (raddr_b == '0)) rdata_b = '0;
`ifdef REGFILE_BYPASS_EN
      else if (wr_ok && (waddr == raddr_b)) rdata_b = wdata;
`endif
   end

   // Dump capture always sees the post-write value, independent of the read bypass.
   always_comb begin
      cap_addr = (state == SEND) ? dump_idx + AW'(1) : '0;
      cap_val  = regs[cap_addr];
      if ((ZERO_R0 != 0) && (cap_addr == '0)) cap_val = '0;
      else if (wr_ok && (waddr == cap_addr)) cap_val = wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dump_idx  <= '0;
         dump_data <= '0;
      end else begin
         state     <= state_nxt;
         dump_idx  <= idx_nxt;
         dump_data <= data_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = dump_idx;
      data_nxt   = dump_data;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_done  = 1'b0;
      case (state)
         IDLE: begin
            if (dump_req) begin
               state_nxt = SEND;
               idx_nxt   = '0;
               data_nxt  = cap_val;
            end
         end
         SEND: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            if (dump_ready) begin
               if (dump_idx == AW'(NREG - 1)) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt  = cap_addr;
                  data_nxt = cap_val;
               end
            end
         end
         DONE: begin
            dump_done = 1'b1;
            dump_busy = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_dbg.sv
// tb/tb_regfile_dbg.sv - Directed self-checking bench for regfile_dbg (default and 32x16 builds).
module tb_regfile_dbg;

   logic        clk;
   logic        rst;
   logic        we;
   logic [2:0]  waddr;
   logic [15:0] wdata;
   logic [2:0]  raddr_a, raddr_b;
   logic [15:0] rdata_a, rdata_b;
   logic        dump_req, dump_ready;
   logic        dump_valid, dump_busy, dump_done;
   logic [2:0]  dump_idx;
   logic [15:0] dump_data;

   logic        p_we;
   logic [3:0]  p_waddr;
   logic [31:0] p_wdata;
   logic [3:0]  p_raddr_a, p_raddr_b;
   logic [31:0] p_rdata_a, p_rdata_b;
   logic        p_dump_req, p_dump_ready;
   logic        p_dump_valid, p_dump_busy, p_dump_done;
   logic [3:0]  p_dump_idx;
   logic [31:0] p_dump_data;

   int checks = 0;
   int errors = 0;

   regfile_dbg dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dump_valid),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
      .dump_done(dump_done)
   );

   regfile_dbg #(.DATA_W(32), .NREG(16), .ZERO_R0(0)) dut_p (
      .clk(clk), .rst(rst), .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
      .raddr_a(p_raddr_a), .raddr_b(p_raddr_b), .rdata_a(p_rdata_a), .rdata_b(p_rdata_b),
      .dump_req(p_dump_req), .dump_ready(p_dump_ready), .dump_valid(p_dump_valid),
      .dump_idx(p_dump_idx), .dump_data(p_dump_data), .dump_busy(p_dump_busy),
      .dump_done(p_dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      #1;
      checks++;
      if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b want 000", {dump_valid, dump_busy, dump_done});
      end
      checks++;
      if (dump_idx !== 3'd0 || dump_data !== 16'd0) begin
         errors++; $display("FAIL reset_dump got idx %0d data %0d want 0 0", dump_idx, dump_data);
      end
      for (int i = 0; i < 8; i++) begin
         raddr_a = 3'(i);
         #1;
         checks++;
         if (rdata_a !== 16'd0) begin
            errors++; $display("FAIL reset_reg%0d got %0d want 0", i, rdata_a);
         end
      end
   endtask

   task automatic test_write();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); we = 1'b1; waddr = 3'd1; wdata = 16'd5;
      @(negedge clk); waddr = 3'd2; wdata = 16'd9;
      @(negedge clk); waddr = 3'd0; wdata = 16'hFFFF;
      @(negedge clk); we = 1'b0; raddr_a = 3'd1; raddr_b = 3'd2;
      #1;
      checks++;
      if (rdata_a !== 16'd5) begin
         errors++; $display("FAIL write_r1 got %0d want 5", rdata_a);
      end
      checks++;
      if (rdata_b !== 16'd9) begin
         errors++; $display("FAIL write_r2 got %0d want 9", rdata_b);
      end
      raddr_a = 3'd0;
      #1;
      checks++;
      if (rdata_a !== 16'd0) begin
         errors++; $display("FAIL write_r0 got %h want 0000", rdata_a);
      end
   endtask

   task automatic test_same_cycle();
      logic [15:0] exp_now;
`ifdef REGFILE_BYPASS_EN
      exp_now = 16'd7;
`else
      exp_now = 16'd0;
`endif
      @(negedge clk); we = 1'b1; waddr = 3'd3; wdata = 16'd7; raddr_a = 3'd3;
      #1;
      checks++;
      if (rdata_a !== exp_now) begin
         errors++; $display("FAIL same_cycle_read got %0d want %0d", rdata_a, exp_now);
      end
      @(negedge clk); we = 1'b0;
      #1;
      checks++;
      if (rdata_a !== 16'd7) begin
         errors++; $display("FAIL next_cycle_read got %0d want 7", rdata_a);
      end
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (dump_done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL %s_timeout got no dump_done want dump_done", name);
      end
   endtask

   task automatic test_full_dump();
      for (int i = 1; i < 8; i++) begin
         @(negedge clk); we = 1'b1; waddr = 3'(i); wdata = 16'(i);
      end
      @(negedge clk); we = 1'b0; dump_ready = 1'b1; dump_req = 1'b1;
      #1;
      checks++;
      if (dump_valid !== 1'b0) begin
         errors++; $display("FAIL dump_latency got valid %b want 0", dump_valid);
      end
      @(negedge clk); dump_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== 3'(i) || dump_data !== 16'(i)) begin
            errors++;
            $display("FAIL dump_beat%0d got v%b b%b idx %0d data %0d want v1 b1 idx %0d data %0d",
                     i, dump_valid, dump_busy, dump_idx, dump_data, i, i);
         end
         @(negedge clk);
      end
      checks++;
      if ({dump_valid, dump_done, dump_busy} !== 3'b011) begin
         errors++; $display("FAIL dump_done_cycle got v/d/b %b want 011", {dump_valid, dump_done, dump_busy});
      end
      @(negedge clk);
      checks++;
      if ({dump_valid, dump_done, dump_busy} !== 3'b000) begin
         errors++; $display("FAIL dump_idle_after got v/d/b %b want 000", {dump_valid, dump_done, dump_busy});
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk); dump_ready = 1'b1; dump_req = 1'b1;
      @(negedge clk); dump_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dump_idx !== 3'd2 || dump_data !== 16'd2) begin
         errors++; $display("FAIL bp_reach_idx2 got idx %0d data %0d want 2 2", dump_idx, dump_data);
      end
      dump_ready = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 16'd99;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (dump_valid !== 1'b1 || dump_idx !== 3'd2 || dump_data !== 16'd2) begin
            errors++; $display("FAIL bp_hold%0d got v%b idx %0d data %0d want v1 idx 2 data 2",
                               c, dump_valid, dump_idx, dump_data);
         end
         we = (c == 1); waddr = 3'd3; wdata = 16'd33;
         if (c == 2) dump_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (dump_idx !== 3'd3 || dump_data !== 16'd33) begin
         errors++; $display("FAIL bp_idx3 got idx %0d data %0d want 3 33", dump_idx, dump_data);
      end
      we = 1'b1; waddr = 3'd4; wdata = 16'd44;
      @(negedge clk); we = 1'b0;
      checks++;
      if (dump_idx !== 3'd4 || dump_data !== 16'd44) begin
         errors++; $display("FAIL bp_same_edge_write got idx %0d data %0d want 4 44", dump_idx, dump_data);
      end
      wait_done("bp");
   endtask

   task automatic test_abort();
      @(negedge clk); dump_ready = 1'b1; dump_req = 1'b1;
      @(negedge clk); dump_req = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (dump_idx !== 3'd4) begin
         errors++; $display("FAIL abort_reach_idx4 got idx %0d want 4", dump_idx);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_idx !== 3'd0 || dump_data !== 16'd0) begin
         errors++; $display("FAIL abort_flags got v/b/d %b idx %0d data %0d want 000 0 0",
                            {dump_valid, dump_busy, dump_done}, dump_idx, dump_data);
      end
      for (int i = 1; i < 8; i++) begin
         raddr_b = 3'(i);
         #1;
         checks++;
         if (rdata_b !== 16'd0) begin
            errors++; $display("FAIL abort_reg%0d got %0d want 0", i, rdata_b);
         end
      end
      @(negedge clk); rst = 1'b1; dump_req = 1'b1;
      @(negedge clk);
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 3'd0 || dump_data !== 16'd0) begin
         errors++; $display("FAIL abort_restart got v%b idx %0d data %0d want v1 idx 0 data 0",
                            dump_valid, dump_idx, dump_data);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (dump_done !== 1'b1) begin
         errors++; $display("FAIL held_req_done got %b want 1", dump_done);
      end
      @(negedge clk);
      checks++;
      if (dump_valid !== 1'b0 || dump_done !== 1'b0) begin
         errors++; $display("FAIL held_req_idle got v%b d%b want v0 d0", dump_valid, dump_done);
      end
      @(negedge clk); dump_req = 1'b0;
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 3'd0) begin
         errors++; $display("FAIL held_req_restart got v%b idx %0d want v1 idx 0", dump_valid, dump_idx);
      end
      wait_done("held");
   endtask

   task automatic test_params();
      int          beats = 0;
      bit          seen = 1'b0;
      logic [3:0]  last_idx = '0;
      logic [31:0] last_data = '0;
      @(negedge clk); p_we = 1'b1; p_waddr = 4'd0; p_wdata = 32'hDEADBEEF;
      @(negedge clk); p_waddr = 4'd15;
      @(negedge clk); p_we = 1'b0; p_raddr_a = 4'd0; p_raddr_b = 4'd15;
      #1;
      checks++;
      if (p_rdata_a !== 32'hDEADBEEF || p_rdata_b !== 32'hDEADBEEF) begin
         errors++; $display("FAIL param_read got %h %h want deadbeef deadbeef", p_rdata_a, p_rdata_b);
      end
      p_dump_ready = 1'b1; p_dump_req = 1'b1;
      @(negedge clk); p_dump_req = 1'b0;
      checks++;
      if (p_dump_valid !== 1'b1 || p_dump_idx !== 4'd0 || p_dump_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL param_first_beat got v%b idx %0d data %h want v1 idx 0 data deadbeef",
                            p_dump_valid, p_dump_idx, p_dump_data);
      end
      for (int c = 0; c < 40 && !seen; c++) begin
         if (p_dump_done) seen = 1'b1;
         else if (p_dump_valid) begin
            beats++; last_idx = p_dump_idx; last_data = p_dump_data;
         end
         if (!seen) @(negedge clk);
      end
      checks++;
      if (!seen || beats != 16) begin
         errors++; $display("FAIL param_beats got %0d done %b want 16 done 1", beats, seen);
      end
      checks++;
      if (last_idx !== 4'd15 || last_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL param_last_beat got idx %0d data %h want 15 deadbeef", last_idx, last_data);
      end
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      dump_req = 1'b0; dump_ready = 1'b0;
      p_we = 1'b0; p_waddr = '0; p_wdata = '0; p_raddr_a = '0; p_raddr_b = '0;
      p_dump_req = 1'b0; p_dump_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_write();
      test_same_cycle();
      test_full_dump();
      test_backpressure();
      test_abort();
      test_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
